// File: rtl/awgn_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : awgn_ctrl
// Description : Sample-issue controller for a Box-Muller AWGN datapath with
//               credit-based output FIFO, burst / continuous run modes.
// Revision    : 1.0  initial release
// ============================================================================
module awgn_ctrl #(
    parameter int PIPE_LAT   = 4,   // 1..15
    parameter int FIFO_DEPTH = 4    // power of two, 2..16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] burst_len,
    output logic        lfsr_en,
    input  logic [15:0] x0_in,
    input  logic [15:0] x1_in,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = 6;
    localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [15:0]          burst_q;
    logic [15:0]          issued;
    logic [PIPE_LAT-1:0]  tag;
    logic [4:0]           inflight;
    logic [31:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fifo_count;
    logic                 push;
    logic                 pop;
    logic                 start_acc;
    logic                 burst_hit;
    logic                 credit_ok;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            inflight = inflight + {4'd0, tag[i]};
        end
    end

    // Everything issued but not yet popped must fit in the FIFO.
    assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(inflight)) < DEPTH_C;
    assign burst_hit = (burst_q != 16'd0) && (issued == burst_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lfsr_en   = 1'b0;
        done      = 1'b0;
        start_acc = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                if (stop || burst_hit) begin
                    state_nxt = DRAIN;
                end else begin
                    lfsr_en = credit_ok;
                end
            end
            DRAIN: begin
                if ((inflight == 5'd0) && (fifo_count == '0)) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturation only matters in continuous mode; a burst stops at burst_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_q <= 16'd0;
            issued  <= 16'd0;
        end else if (start_acc) begin
            burst_q <= burst_len;
            issued  <= 16'd0;
        end else if (lfsr_en && (issued != 16'hFFFF)) begin
            issued  <= issued + 16'd1;
        end
    end

    generate
        if (PIPE_LAT == 1) begin : g_tag_single
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tag <= '0;
                end else begin
                    tag <= lfsr_en;
                end
            end
        end else begin : g_tag_shift
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tag <= '0;
                end else begin
                    tag <= {tag[PIPE_LAT-2:0], lfsr_en};
                end
            end
        end
    endgenerate

    assign push = tag[PIPE_LAT-1];
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {x0_in, x1_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign out_valid = (fifo_count != '0);
    assign out_data  = mem[rd_ptr];
    assign busy      = (state != IDLE);

    // The credit rule makes a write into a full FIFO unreachable.
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(push && (fifo_count == FULL_C)));

endmodule
`default_nettype wire

// File: doc/awgn_ctrl.md
AWGN_CTRL -- requirements
Module: awgn_ctrl

Interface
REQ-001 Parameter PIPE_LAT, default 4: cycles from lfsr_en high to matching x0_in/x1_in valid; legal range 1..15.
REQ-002 Parameter FIFO_DEPTH, default 4: output FIFO entries, power of two, range 2..16.
REQ-003 Ports, one per line:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins a run, sampled in IDLE only.
- stop  in  1  level; ends an open-ended or burst run early.
- burst_len  in  16  pairs to generate; 0 = continuous until stop; sampled on accepted start.
- lfsr_en  out  1  advances the LFSRs and issues one sample slot to the Box-Muller datapath.
- x0_in  in  16  datapath cosine-branch sample.
- x1_in  in  16  datapath sine-branch sample.
- out_data  out  32  {x0,x1} pair at FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse on DRAIN->IDLE.

Function
REQ-004 FSM states IDLE, RUN, DRAIN; encoding is free.
REQ-005 IDLE->RUN on start; burst_len latched and issue counter cleared in the same cycle.
REQ-006 In RUN: lfsr_en=1 iff fifo_count + inflight < FIFO_DEPTH, and issued < burst_len when burst_len != 0.
REQ-007 inflight = number of 1s in a PIPE_LAT-deep tag shift register; bit 0 loads lfsr_en each cycle.
REQ-008 When the tag leaves stage PIPE_LAT, {x0_in,x1_in} is written to the FIFO that same edge, so out_valid rises PIPE_LAT+1 cycles after the issuing lfsr_en cycle.
REQ-009 The credit rule in REQ-006 guarantees no FIFO write when full; the write happens regardless and an overflow is a design error, checked by assertion.
REQ-010 Simultaneous push and pop leaves fifo_count unchanged; both operations take effect.
REQ-011 A pop when empty is impossible because out_valid=0; out_data is don't-care when empty.
REQ-012 RUN->DRAIN when stop=1, or when issued == burst_len != 0; lfsr_en is 0 from that cycle on.
REQ-013 DRAIN->IDLE when inflight == 0 and fifo_count == 0; done=1 for exactly that cycle.
REQ-014 Samples in flight are always delivered in issue order; none are dropped or discarded on stop.
REQ-015 start is ignored in RUN/DRAIN; stop is ignored in IDLE/DRAIN.
REQ-016 The 16-bit issue counter saturates at 0xFFFF in continuous mode (burst_len=0) and does not wrap.
REQ-017 busy = (state != IDLE).

Reset
REQ-018 While reset is high: state=IDLE, lfsr_en=0, out_valid=0, busy=0, done=0, tag register=0, FIFO pointers and count=0, issue counter=0, latched burst_len=0.
REQ-019 Reset asserted mid-RUN or mid-DRAIN flushes in-flight and FIFO contents with no done pulse.
REQ-020 The first start is accepted on the first rising edge after reset deasserts.

Verification
REQ-021 Scenario: reset, start with burst_len=3, out_ready=1, PIPE_LAT=4 -> lfsr_en high 3 consecutive cycles; 3 pairs appear in order starting 5 cycles after the first lfsr_en; done pulses one cycle after the last pop.
REQ-022 Scenario: burst_len=10, out_ready=0 -> exactly 4 lfsr_en pulses; FIFO fills and out_valid stays 1; on out_ready=1, issuing resumes and the total is 10 pairs.
REQ-023 Scenario: burst_len=0, stop raised after 20 pulses -> lfsr_en drops in the stop cycle; all inflight pairs delivered; then done.
REQ-024 Scenario: start during RUN and stop in IDLE -> no change in state, counters or outputs.
REQ-025 Scenario: reset pulse while 2 pairs are in flight and 3 are in the FIFO -> next cycle out_valid=0, busy=0, no done; a fresh start with burst_len=1 yields exactly 1 pair.
REQ-026 Scenario: out_ready toggling every cycle with burst_len=8 -> push and pop coincide without loss; an x0_in/x1_in counting pattern is received as 8 consecutive pairs.
